// File: rtl/irq_controller_pkg.sv
// irq_controller_pkg: shared FSM encoding, cfg addresses and vector defaults
package irq_controller_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERVICE = 2'd2} state_t;
  localparam logic CFG_MASK = 1'b0;
  localparam logic CFG_PCLR = 1'b1;
  localparam logic [15:0] VEC_BASE_DEF = 16'h0010;
  localparam logic [15:0] VEC_STRIDE_DEF = 16'h0004;
endpackage

// File: rtl/irq_edge_sync.sv
// irq_edge_sync: 2-FF synchroniser plus rising-edge detect for one interrupt line
module irq_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic irq,
  output logic rise
);
  logic [2:0] s;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s <= '0;
    else s <= {s[1:0], irq};
  assign rise = s[1] & ~s[2];
endmodule

// File: rtl/irq_controller.sv
// irq_controller: prioritised interrupt controller with mask, pending latch and return-PC hold
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter logic [15:0] VEC_BASE = VEC_BASE_DEF,
  parameter logic [15:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_in,
  output logic               io_interrupt,
  input  logic               int_ack,
  input  logic               vec_push,
  input  logic               ret_push,
  input  logic [15:0]        d_in,
  output logic [15:0]        d_out,
  output logic               d_oe,
  input  logic               cfg_we,
  input  logic               cfg_addr,
  input  logic [15:0]        cfg_wdata,
  output logic [NUM_SRC-1:0] mask,
  output logic [NUM_SRC-1:0] pending,
  output logic [3:0]         cur_id
);
  state_t state_q, state_d;
  logic [NUM_SRC-1:0] rise, act, pclr, aclr;
  logic [15:0] pc_q, pc_d;
  logic [3:0] sel, cur_d;
  logic irq_d;
  logic unused_wdata;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
    irq_edge_sync u_sync (.clk(clk), .rst_n(rst_n), .irq(irq_in[i]), .rise(rise[i]));
  end
  assign unused_wdata = ^cfg_wdata;
  assign act = pending & mask;
  assign pclr = (cfg_we && cfg_addr == CFG_PCLR) ? cfg_wdata[NUM_SRC-1:0] : '0;
  assign aclr = (state_q == REQ && int_ack) ? NUM_SRC'(1) << cur_id : '0;
  always_comb begin
    sel = '0;
    for (int j = NUM_SRC - 1; j >= 0; j--)
      if (act[j]) sel = 4'(j);
  end
  always_comb begin
    state_d = state_q;
    irq_d = io_interrupt;
    cur_d = cur_id;
    pc_d = pc_q;
    case (state_q)
      IDLE: if (|act) begin
        cur_d = sel;
        irq_d = 1'b1;
        state_d = REQ;
      end
      REQ: if (int_ack) begin
        pc_d = d_in;
        irq_d = 1'b0;
        state_d = SERVICE;
      end
      SERVICE: state_d = ret_push ? IDLE : SERVICE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      io_interrupt <= 1'b0;
      cur_id <= '0;
      pc_q <= '0;
      mask <= '0;
      pending <= '0;
    end else begin
      state_q <= state_d;
      io_interrupt <= irq_d;
      cur_id <= cur_d;
      pc_q <= pc_d;
      mask <= (cfg_we && cfg_addr == CFG_MASK) ? cfg_wdata[NUM_SRC-1:0] : mask;
      pending <= (pending & ~(pclr | aclr)) | rise;
    end
  assign d_oe = vec_push | ret_push;
  assign d_out = vec_push ? 16'(VEC_BASE + 16'(cur_id) * VEC_STRIDE) : ret_push ? pc_q : 16'h0000;
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed self-checking bench for irq_controller
module tb_irq_controller;
  import irq_controller_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] irq_in;
  logic io_interrupt, int_ack, vec_push, ret_push, d_oe, cfg_we, cfg_addr;
  logic [15:0] d_in, d_out, cfg_wdata;
  logic [7:0] mask, pending;
  logic [3:0] cur_id;
  int total = 0;
  int bad = 0;

  irq_controller dut (
    .clk(clk), .rst_n(rst_n), .irq_in(irq_in), .io_interrupt(io_interrupt),
    .int_ack(int_ack), .vec_push(vec_push), .ret_push(ret_push), .d_in(d_in),
    .d_out(d_out), .d_oe(d_oe), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .mask(mask), .pending(pending), .cur_id(cur_id)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic a, input logic [15:0] v);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = v;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic ack(input logic [15:0] pc);
    int_ack = 1'b1; d_in = pc;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic ret();
    ret_push = 1'b1;
    tick();
    ret_push = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; irq_in = '0; int_ack = 0; vec_push = 0; ret_push = 0;
    d_in = '0; cfg_we = 0; cfg_addr = 0; cfg_wdata = '0;
    tick(3);
    chk("rst_irq", io_interrupt, 0);
    chk("rst_mask", mask, 0);
    chk("rst_pend", pending, 0);
    chk("rst_cur", cur_id, 0);
    chk("rst_oe", d_oe, 0);
    chk("rst_dout", d_out, 0);
    rst_n = 1'b1;
    tick();
    cfg(CFG_MASK, 16'h00FF);
    chk("mask_ff", mask, 8'hFF);
    // single source 5
    irq_in[5] = 1'b1;
    tick(2);
    chk("p5_early", pending, 0);
    tick();
    chk("p5_set", pending, 8'h20);
    chk("p5_noirq", io_interrupt, 0);
    tick();
    irq_in[5] = 1'b0;
    chk("p5_irq", io_interrupt, 1);
    chk("p5_cur", cur_id, 5);
    vec_push = 1'b1; #1;
    chk("p5_vec", d_out, 16'h0024);
    chk("p5_vec_oe", d_oe, 1);
    ret_push = 1'b1; #1;
    chk("vec_wins", d_out, 16'h0024);
    ret_push = 1'b0; vec_push = 1'b0; #1;
    ack(16'h1234);
    chk("ack_irq", io_interrupt, 0);
    chk("ack_state", dut.state_q, SERVICE);
    chk("ack_pend", pending, 0);
    ret_push = 1'b1; #1;
    chk("ret_pc", d_out, 16'h1234);
    chk("ret_oe", d_oe, 1);
    tick();
    ret_push = 1'b0;
    chk("ret_idle", dut.state_q, IDLE);
    tick();
    chk("idle_quiet", io_interrupt, 0);
    // two sources, 2 wins then 6
    irq_in = 8'h44;
    tick(4);
    irq_in = '0;
    chk("pri_cur2", cur_id, 2);
    chk("pri_irq", io_interrupt, 1);
    ack(16'h5555);
    chk("pri_pend", pending, 8'h40);
    ret();
    chk("pri_gap", io_interrupt, 0);
    tick();
    chk("pri_irq6", io_interrupt, 1);
    chk("pri_cur6", cur_id, 6);
    ack(16'h0001);
    ret();
    // masked source, enabled later
    cfg(CFG_MASK, 16'h0000);
    irq_in[0] = 1'b1;
    tick(4);
    irq_in[0] = 1'b0;
    chk("m_pend", pending, 8'h01);
    chk("m_noirq", io_interrupt, 0);
    cfg(CFG_MASK, 16'h0001);
    chk("m_wr_gap", io_interrupt, 0);
    tick();
    chk("m_irq", io_interrupt, 1);
    chk("m_cur", cur_id, 0);
    ack(16'h0002);
    ret();
    // new edge on the ack cycle survives the clear
    cfg(CFG_MASK, 16'h00FF);
    irq_in[3] = 1'b1;
    tick(4);
    irq_in[3] = 1'b0;
    chk("sw_cur", cur_id, 3);
    tick(3);
    irq_in[3] = 1'b1;
    tick(2);
    ack(16'h0BAD);
    irq_in[3] = 1'b0;
    chk("sw_pend", pending, 8'h08);
    chk("sw_irq0", io_interrupt, 0);
    ret();
    tick();
    chk("sw_rereq", io_interrupt, 1);
    chk("sw_cur2", cur_id, 3);
    // cfg clear in REQ keeps the request
    cfg(CFG_PCLR, 16'h0008);
    chk("pclr_pend", pending, 0);
    chk("pclr_irq", io_interrupt, 1);
    ack(16'h4321);
    chk("svc_state", dut.state_q, SERVICE);
    // reset in SERVICE
    irq_in = 8'h81;
    tick(3);
    chk("r_pend", pending, 8'h81);
    irq_in = '0;
    rst_n = 1'b0; #1;
    chk("r_irq", io_interrupt, 0);
    chk("r_pend0", pending, 0);
    chk("r_mask0", mask, 0);
    ret_push = 1'b1; #1;
    chk("r_pc0", d_out, 0);
    ret_push = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(5);
    chk("r_quiet", io_interrupt, 0);
    chk("r_quiet_p", pending, 0);
    cfg(CFG_MASK, 16'h00FF);
    irq_in[7] = 1'b1;
    tick(4);
    irq_in[7] = 1'b0;
    chk("r_new_irq", io_interrupt, 1);
    chk("r_new_cur", cur_id, 7);
    vec_push = 1'b1; #1;
    chk("r_vec7", d_out, 16'h002C);
    vec_push = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Prioritised interrupt controller in the IO subsystem, in front of the control unit's `io_interrupt` input.
- Latches rising edges from up to NUM_SRC peripheral lines and applies a software mask.
- Presents one request at a time, supplies the handler vector on the data bus, and holds the interrupted PC until `rit` returns it.
- Drives and responds to the control unit's `io_store_retaddr`, `io_push_int_addr` and `io_push_retaddr` strobes.

Parameters:
- NUM_SRC, 8, number of interrupt sources (1..16).
- VEC_BASE, 16'h0010, handler address for source 0.
- VEC_STRIDE, 16'h0004, address spacing between handler vectors.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- irq_in  in  NUM_SRC  raw peripheral interrupt lines, asynchronous
- io_interrupt  out  1  registered request to control unit
- int_ack  in  1  control unit `io_store_retaddr`; interrupt accepted, return PC present on `d_in`
- vec_push  in  1  control unit `io_push_int_addr`; drive vector on bus
- ret_push  in  1  control unit `io_push_retaddr`; drive saved PC on bus
- d_in  in  16  data bus input
- d_out  out  16  data bus output (vector or return address)
- d_oe  out  1  data bus output enable
- cfg_we  in  1  configuration write strobe
- cfg_addr  in  1  0 = mask register, 1 = pending clear (write-1-to-clear)
- cfg_wdata  in  16  configuration write data; low NUM_SRC bits used
- mask  out  NUM_SRC  current enable mask (1 = enabled)
- pending  out  NUM_SRC  current pending bits
- cur_id  out  4  source currently requested or in service

Behaviour:
- Reset values: `io_interrupt`=0, `mask`=0 (all disabled), `pending`=0, `cur_id`=0, saved return address=0, state=IDLE, both synchroniser stages=0. `d_oe` is 0 and `d_out` is 0 while no push strobe is active.
- Input path:
  - 2-FF synchroniser per `irq_in` bit, then a rising-edge detect against a third registered copy.
  - Edge sets `pending[i]` 3 cycles after the pin rises.
  - Levels are ignored; a held-high line produces exactly one pending set.
- Pending priority, same cycle:
  - A new edge on bit i beats a clear of bit i from either `int_ack` or a cfg clear; the bit stays 1.
  - A cfg clear of a bit not being set clears it.
- Mask write: `cfg_we` & `cfg_addr`=0 loads `mask` next cycle. Masked sources still latch pending.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if `(pending & mask) != 0`, select the lowest index as `cur_id` (fixed priority, 0 highest). Set `io_interrupt`<=1 and go to REQ. Arbitration is 1 cycle after pending is visible.
  - REQ: `io_interrupt` held at 1. On `int_ack`: save `d_in` as the return PC, clear `pending[cur_id]` (subject to the set-wins rule), set `io_interrupt`<=0, go to SERVICE.
    - Masking or cfg-clearing `cur_id` while in REQ does not withdraw the request; it stays committed until ack.
    - CPU-side masking may hold REQ indefinitely; no timeout.
  - SERVICE: no nesting. New pending bits accumulate. On `ret_push`, go to IDLE next cycle; arbitration may re-request on the cycle after.
- Acknowledge and push strobes outside their state:
  - `int_ack` in IDLE or SERVICE is ignored.
  - `ret_push` in IDLE or REQ still drives the saved PC but does not change state.
- Bus drive is combinational from the strobes. `vec_push` and `ret_push` are never simultaneous; if both are high, `vec_push` wins.
  - `vec_push`=1: `d_oe`=1, `d_out` = `VEC_BASE + cur_id*VEC_STRIDE`, 16-bit wrap-around on overflow.
  - `ret_push`=1: `d_oe`=1, `d_out` = saved PC.
- Reset mid-operation: an asynchronous reset in any state returns everything to reset values immediately. In-flight requests are lost.

Decomposition:
- Shared io package holds:
  - the FSM state encoding (IDLE=0, REQ=1, SERVICE=2);
  - the cfg address constants CFG_MASK=0 and CFG_PCLR=1;
  - the default VEC_BASE and VEC_STRIDE.
- One natural sub-module: `irq_edge_sync`, per-source synchroniser plus rising-edge detect, instantiated NUM_SRC times.
- Priority encoder, pending logic and FSM stay in the top module.

Test Plan:
- Mask=8'hFF, pulse `irq_in[5]` → `pending[5]`=1 after 3 cycles; `io_interrupt`=1 one cycle later with `cur_id`=5. `vec_push` gives `d_out`=16'h0024, `d_oe`=1.
- Mask=8'hFF, raise `irq_in[2]` and `irq_in[6]` together → `cur_id`=2 first. After ack then `ret_push`, `cur_id`=6 and `io_interrupt` re-asserts 2 cycles after `ret_push`.
- REQ with `int_ack` and `d_in`=16'h1234 → `io_interrupt`=0, state SERVICE. Later `ret_push` gives `d_out`=16'h1234; state IDLE next cycle.
- Mask=0, pulse `irq_in[0]` → `pending[0]`=1 and `io_interrupt` stays 0. Write mask=1 → `io_interrupt`=1 two cycles after the write.
- `irq_in[3]` rising edge arrives the same cycle that `int_ack` clears `pending[3]` → `pending[3]` remains 1 and is re-requested after `ret_push`.
- Assert `rst_n`=0 in SERVICE with pending=8'h81 → `io_interrupt`, `pending`, `mask` and saved PC all 0 immediately. After release, no request until a new edge arrives and the mask is set.
